// File: rtl/player_ctl_1.sv
// player_ctl_1: per-frame movement, jump and walk-animation
// controller for player 1, feeding draw_player_1.
package state_pkg;
  typedef enum logic [2:0] {
    IDLE, RIGHT1, RIGHT2, LEFT1, LEFT2
  } State;
endpackage

module player_ctl_1 #(
  parameter logic [11:0] X_START     = 12'd100,
  parameter logic [11:0] X_MIN       = 12'd0,
  parameter logic [11:0] X_MAX       = 12'd984,
  parameter logic [11:0] Y_GROUND    = 12'd100,
  parameter logic [11:0] JUMP_H      = 12'd80,
  parameter int          STEP_X      = 4,
  parameter int          STEP_Y      = 4,
  parameter int          ANIM_FRAMES = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_tick,
  input  logic            key_left,
  input  logic            key_right,
  input  logic            key_jump,
  output logic [11:0]     xpos_player1,
  output logic [11:0]     ypos_player1,
  output state_pkg::State state
);
  import state_pkg::*;

  typedef enum logic [1:0] {
    D_NONE, D_RIGHT, D_LEFT
  } dir_t;

  typedef enum logic [1:0] {
    J_GROUND, J_RISE, J_FALL
  } jump_t;

  localparam logic [12:0] SX = 13'(STEP_X);
  localparam logic [12:0] SY = 13'(STEP_Y);
  localparam logic [11:0] Y_TOP = Y_GROUND - JUMP_H;
  localparam int CW =
    (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(ANIM_FRAMES - 1);

  jump_t         jst, jst_n;
  dir_t          dir, pdir, pdir_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          phase, phase_n;
  logic [11:0]   x_n, y_n;
  State          st_n;

  // Key decode; both keys together cancel out.
  always_comb begin
    dir = D_NONE;
    if (key_right && !key_left)
      dir = D_RIGHT;
    else if (key_left && !key_right)
      dir = D_LEFT;
  end

  // Next position, jump phase and sprite state on a frame tick.
  always_comb begin
    x_n     = xpos_player1;
    y_n     = ypos_player1;
    jst_n   = jst;
    pdir_n  = pdir;
    cnt_n   = cnt;
    phase_n = phase;
    st_n    = state;
    if (frame_tick) begin
      pdir_n = dir;
      unique case (dir)
        D_RIGHT: begin
          if ({1'b0, xpos_player1} + SX
              >= {1'b0, X_MAX})
            x_n = X_MAX;
          else
            x_n = xpos_player1 + SX[11:0];
        end
        D_LEFT: begin
          if ({1'b0, xpos_player1}
              < {1'b0, X_MIN} + SX)
            x_n = X_MIN;
          else
            x_n = xpos_player1 - SX[11:0];
        end
        default: x_n = xpos_player1;
      endcase
      unique case (jst)
        J_GROUND: begin
          if (key_jump)
            jst_n = J_RISE;
        end
        J_RISE: begin
          if ({1'b0, ypos_player1}
              <= {1'b0, Y_TOP} + SY) begin
            y_n   = Y_TOP;
            jst_n = J_FALL;
          end else begin
            y_n = ypos_player1 - SY[11:0];
          end
        end
        J_FALL: begin
          if ({1'b0, ypos_player1} + SY
              >= {1'b0, Y_GROUND}) begin
            y_n   = Y_GROUND;
            jst_n = J_GROUND;
          end else begin
            y_n = ypos_player1 + SY[11:0];
          end
        end
        default: jst_n = J_GROUND;
      endcase
      if (dir != pdir) begin
        cnt_n   = '0;
        phase_n = 1'b0;
      end else if (dir != D_NONE
                   && jst == J_GROUND) begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          phase_n = ~phase;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      unique case (dir)
        D_RIGHT: st_n = phase_n ? RIGHT2 : RIGHT1;
        D_LEFT:  st_n = phase_n ? LEFT2 : LEFT1;
        default: st_n = IDLE;
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      xpos_player1 <= X_START;
      ypos_player1 <= Y_GROUND;
      state        <= IDLE;
      jst          <= J_GROUND;
      pdir         <= D_NONE;
      cnt          <= '0;
      phase        <= 1'b0;
    end else begin
      xpos_player1 <= x_n;
      ypos_player1 <= y_n;
      state        <= st_n;
      jst          <= jst_n;
      pdir         <= pdir_n;
      cnt          <= cnt_n;
      phase        <= phase_n;
    end
  end
endmodule

// File: tb/tb_player_ctl_1.sv
// tb_player_ctl_1: directed bench for player_ctl_1 with
// a frame-level behavioural model and per-cycle compare.
module tb_player_ctl_1;
  import state_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic        key_left = 1'b0;
  logic        key_right = 1'b0;
  logic        key_jump = 1'b0;
  logic [11:0] xpos_player1;
  logic [11:0] ypos_player1;
  State        state;

  player_ctl_1 dut (
    .clk(clk),
    .rst(rst),
    .frame_tick(frame_tick),
    .key_left(key_left),
    .key_right(key_right),
    .key_jump(key_jump),
    .xpos_player1(xpos_player1),
    .ypos_player1(ypos_player1),
    .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit en = 1'b0;

  // model: position, airborne mode, run length
  int   mx = 100;
  int   my = 100;
  int   mode = 0;
  int   run = 0;
  int   pd = 0;
  State mst = IDLE;

  task automatic chk(input string nm,
                     input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic model(input bit ft, input bit l,
                       input bit r, input bit j,
                       input bit rs);
    int  d;
    bit  gnd;
    if (rs) begin
      mx = 100; my = 100; mode = 0;
      run = 0; pd = 0; mst = IDLE;
      return;
    end
    if (!ft) return;
    d = (r && !l) ? 1 : ((l && !r) ? 2 : 0);
    if (d == 1) mx = (mx + 4 > 984) ? 984 : mx + 4;
    if (d == 2) mx = (mx - 4 < 0) ? 0 : mx - 4;
    gnd = (mode == 0);
    case (mode)
      0: if (j) mode = 1;
      1: begin
        my -= 4;
        if (my <= 20) begin my = 20; mode = 2; end
      end
      default: begin
        my += 4;
        if (my >= 100) begin my = 100; mode = 0; end
      end
    endcase
    if (d != pd) run = 0;
    else if (d != 0 && gnd) run++;
    pd = d;
    if (d == 0) mst = IDLE;
    else if (d == 1)
      mst = ((run / 8) % 2 == 1) ? RIGHT2 : RIGHT1;
    else
      mst = ((run / 8) % 2 == 1) ? LEFT2 : LEFT1;
  endtask

  task automatic step(input bit ft, input bit l,
                      input bit r, input bit j,
                      input bit rs);
    frame_tick = ft;
    key_left   = l;
    key_right  = r;
    key_jump   = j;
    rst        = rs;
    @(posedge clk);
    model(ft, l, r, j, rs);
    #1;
  endtask

  task automatic ticks(input int n, input bit l,
                       input bit r, input bit j);
    for (int i = 0; i < n; i++) step(1, l, r, j, 0);
  endtask

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    if (en) begin
      chk("x", int'(xpos_player1), mx);
      chk("y", int'(ypos_player1), my);
      chk("state", int'(state), int'(mst));
    end
  end

  initial begin
    @(negedge clk);
    step(1, 0, 1, 1, 1);
    step(1, 0, 1, 1, 1);
    en = 1'b1;
    chk("rst_x", int'(xpos_player1), 100);
    chk("rst_y", int'(ypos_player1), 100);
    chk("rst_st", int'(state), int'(IDLE));
    // no tick: outputs hold
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
    chk("hold_x", int'(xpos_player1), 100);
    // walk right 20 ticks
    ticks(8, 0, 1, 0);
    chk("walk8", int'(state), int'(RIGHT1));
    ticks(1, 0, 1, 0);
    chk("walk9", int'(state), int'(RIGHT2));
    ticks(8, 0, 1, 0);
    chk("walk17", int'(state), int'(RIGHT1));
    ticks(3, 0, 1, 0);
    chk("walk_x", int'(xpos_player1), 180);
    chk("walk_st", int'(state), int'(RIGHT1));
    // both keys, release, right again
    ticks(3, 1, 1, 0);
    chk("both_st", int'(state), int'(IDLE));
    chk("both_x", int'(xpos_player1), 180);
    ticks(1, 0, 0, 0);
    ticks(8, 0, 1, 0);
    chk("re8", int'(state), int'(RIGHT1));
    ticks(1, 0, 1, 0);
    chk("re9", int'(state), int'(RIGHT2));
    // sparse ticks
    for (int i = 0; i < 10; i++) step(i[0], 0, 1, 0, 0);
    // right clamp
    ticks(250, 0, 1, 0);
    chk("clamp_r", int'(xpos_player1), 984);
    // left clamp, no wrap
    ticks(260, 1, 0, 0);
    chk("clamp_l", int'(xpos_player1), 0);
    ticks(1, 0, 0, 0);
    // jump with jump held throughout
    ticks(1, 0, 1, 1);
    chk("takeoff", int'(ypos_player1), 100);
    ticks(20, 0, 1, 1);
    chk("apex", int'(ypos_player1), 20);
    ticks(20, 0, 1, 1);
    chk("land", int'(ypos_player1), 100);
    ticks(1, 0, 1, 1);
    chk("retake", int'(ypos_player1), 100);
    ticks(1, 0, 1, 0);
    chk("rise1", int'(ypos_player1), 96);
    ticks(45, 1, 0, 0);
    chk("land2", int'(ypos_player1), 100);
    // reset mid-rise
    ticks(1, 0, 0, 1);
    ticks(10, 0, 0, 0);
    chk("mid", int'(ypos_player1), 60);
    step(1, 0, 1, 0, 1);
    chk("mrst_y", int'(ypos_player1), 100);
    chk("mrst_st", int'(state), int'(IDLE));
    ticks(5, 0, 0, 0);
    chk("stay_y", int'(ypos_player1), 100);
    // random mix
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 99) == 0));
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
